// File: rtl/biquad_cascade.sv
// biquad_cascade: cascaded direct-form-II biquads time-sharing one external 2-cycle signed multiplier
module biquad_cascade #(
  parameter int W = 32,
  parameter int FRAC = 24,
  parameter int SECTIONS = 2,
  parameter int SAT = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      flush,
  input  logic [W-1:0]              x,
  input  logic [5*SECTIONS*W-1:0]   coef,
  output logic [W-1:0]              mult_a,
  output logic [W-1:0]              mult_b,
  input  logic [2*W-1:0]            mult_p,
  output logic                      busy,
  output logic                      finish,
  output logic [W-1:0]              y
);
  localparam logic [3:0] IDLE = 4'd0, FB1 = 4'd1, FB2 = 4'd2, FF1 = 4'd3, FF2 = 4'd4,
                         FF0 = 4'd5, WAIT1 = 4'd6, WAIT2 = 4'd7, FINISH = 4'd8;
  localparam int SW = SECTIONS > 1 ? $clog2(SECTIONS) : 1;
  localparam int NS = 1 << SW;
  localparam logic [SW-1:0] LAST = SW'(SECTIONS - 1);
  logic [3:0]     r_state;
  logic [SW-1:0]  r_s;
  logic [W-1:0]   r_xs, r_wn, r_y;
  logic [2*W-1:0] r_acc_fb, r_acc_ff;
  logic [W-1:0]   r_w1 [NS];
  logic [W-1:0]   r_w2 [NS];
  logic [5*W-1:0] w_cs;
  logic [W-1:0]   w_ff0, w_ff1, w_ff2, w_fb1, w_fb2, w_w1, w_w2, w_wn, w_ys;
  logic [2*W-1:0] w_xe;
  function automatic logic [W-1:0] scale(input logic [2*W-1:0] a);
    logic [2*W-1:0] t;
    t = $signed(a) >>> FRAC;
    return (SAT == 0 || &t[2*W-1:W-1] || ~|t[2*W-1:W-1]) ? t[W-1:0]
         : {t[2*W-1], {(W-1){~t[2*W-1]}}};
  endfunction
  assign w_cs   = (5*W)'(coef >> (5 * W * int'(r_s)));
  assign w_ff0  = w_cs[W-1:0];
  assign w_ff1  = w_cs[2*W-1:W];
  assign w_ff2  = w_cs[3*W-1:2*W];
  assign w_fb1  = w_cs[4*W-1:3*W];
  assign w_fb2  = w_cs[5*W-1:4*W];
  assign w_w1   = r_w1[r_s];
  assign w_w2   = r_w2[r_s];
  assign w_xe   = {{W{r_xs[W-1]}}, r_xs} << FRAC;
  // products land two cycles after issue: FB1/FB2 feed FF1/FF2, FF1/FF2/FF0 feed FF0/WAIT1/WAIT2
  assign w_wn   = scale(r_acc_fb);
  assign w_ys   = scale(r_acc_ff + mult_p);
  assign mult_a = r_state == FB1 ? w_fb1 : r_state == FB2 ? w_fb2 : r_state == FF1 ? w_ff1
                : r_state == FF2 ? w_ff2 : r_state == FF0 ? w_ff0 : '0;
  assign mult_b = (r_state == FB1 || r_state == FF1) ? w_w1
                : (r_state == FB2 || r_state == FF2) ? w_w2 : r_state == FF0 ? w_wn : '0;
  assign busy   = r_state != IDLE;
  assign finish = r_state == FINISH;
  assign y      = r_y;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_s      <= '0;
      r_xs     <= '0;
      r_wn     <= '0;
      r_y      <= '0;
      r_acc_fb <= '0;
      r_acc_ff <= '0;
      for (int i = 0; i < NS; i++) begin
        r_w1[i] <= '0;
        r_w2[i] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (flush)
            for (int i = 0; i < NS; i++) begin
              r_w1[i] <= '0;
              r_w2[i] <= '0;
            end
          if (start) begin
            r_xs    <= x;
            r_s     <= '0;
            r_state <= FB1;
          end
        end
        FB1, FB2: r_state <= r_state + 4'd1;
        FF1: begin
          r_acc_fb <= w_xe - mult_p;
          r_state  <= FF2;
        end
        FF2: begin
          r_acc_fb <= r_acc_fb - mult_p;
          r_state  <= FF0;
        end
        FF0: begin
          r_wn     <= w_wn;
          r_acc_ff <= mult_p;
          r_state  <= WAIT1;
        end
        WAIT1: begin
          r_acc_ff <= r_acc_ff + mult_p;
          r_state  <= WAIT2;
        end
        WAIT2: begin
          r_w2[r_s] <= w_w1;
          r_w1[r_s] <= r_wn;
          r_xs      <= w_ys;
          if (r_s == LAST) begin
            r_y     <= w_ys;
            r_state <= FINISH;
          end else begin
            r_s     <= r_s + SW'(1);
            r_state <= FB1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_biquad_cascade.sv
// tb_biquad_cascade: directed vectors for a 1-section saturating and a 2-section wrapping cascade
module tb_biquad_cascade;
  typedef struct {
    int          d;
    bit          fl;
    logic [159:0] c0;
    logic [159:0] c1;
    logic [31:0] x;
    logic [31:0] e;
  } vec_t;
  logic        clk = 0, rst_n = 0, flush = 0;
  logic        st [2];
  logic [31:0] x = 0;
  logic [319:0] coef = 0;
  logic [31:0] ma [2], mb [2], y_o [2];
  logic [63:0] p1 [2], mp [2];
  logic        fin_o [2], busy_o [2];
  int          total = 0, passed = 0;
  vec_t        v [21];
  logic [159:0] id_c, hfb, half, fir, fb2c, big;
  localparam logic [31:0] ONE = 32'h01000000, NEGH = 32'hFF800000;

  always #5 clk = ~clk;

  biquad_cascade #(.W(32), .FRAC(24), .SECTIONS(1), .SAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .flush(flush), .x(x), .coef(coef[159:0]),
    .mult_a(ma[0]), .mult_b(mb[0]), .mult_p(mp[0]), .busy(busy_o[0]), .finish(fin_o[0]), .y(y_o[0]));
  biquad_cascade #(.W(32), .FRAC(24), .SECTIONS(2), .SAT(0)) u2 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .flush(flush), .x(x), .coef(coef),
    .mult_a(ma[1]), .mult_b(mb[1]), .mult_p(mp[1]), .busy(busy_o[1]), .finish(fin_o[1]), .y(y_o[1]));

  always @(posedge clk)
    for (int i = 0; i < 2; i++) begin
      p1[i] <= {{32{ma[i][31]}}, ma[i]} * {{32{mb[i][31]}}, mb[i]};
      mp[i] <= p1[i];
    end

  function automatic logic [159:0] sec(input logic [31:0] f0, f1, f2, b1, b2);
    return {b2, b1, f2, f1, f0};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic run(input int d, input bit fl, input logic [31:0] xv, input logic [31:0] e, input string nm);
    int cyc;
    x = xv; flush = fl; st[d] = 1;
    @(posedge clk); #1;
    st[d] = 0; flush = 0; x = 32'hDEADBEEF;
    cyc = 1;
    chk({nm, "_busy"}, 64'(busy_o[d]), 64'd1);
    while (!fin_o[d] && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({nm, "_lat"}, 64'(cyc), d == 0 ? 64'd8 : 64'd15);
    chk({nm, "_y"}, 64'(y_o[d]), 64'(e));
    @(posedge clk); #1;
    chk({nm, "_finpulse"}, 64'(fin_o[d]), 64'd0);
    chk({nm, "_idle"}, 64'(busy_o[d]), 64'd0);
  endtask

  initial begin
    int nfin, fcyc;
    logic [31:0] fy;
    st[0] = 0; st[1] = 0;
    id_c = sec(ONE, 0, 0, 0, 0);
    hfb  = sec(ONE, 0, 0, NEGH, 0);
    half = sec(32'h00800000, 0, 0, 0, 0);
    fir  = sec(ONE, 32'h00800000, 32'h00400000, 0, 0);
    fb2c = sec(ONE, 0, 0, 0, 32'hFFC00000);
    big  = sec(32'h7F000000, 0, 0, 0, 0);
    v[0]  = '{0, 1'b0, id_c, id_c, 32'h00800000, 32'h00800000};
    v[1]  = '{0, 1'b0, id_c, id_c, 32'hFF000000, 32'hFF000000};
    v[2]  = '{0, 1'b0, half, id_c, 32'h00000001, 32'h00000000};
    v[3]  = '{0, 1'b0, half, id_c, 32'hFFFFFFFF, 32'hFFFFFFFF};
    v[4]  = '{0, 1'b1, hfb,  id_c, ONE,          ONE};
    v[5]  = '{0, 1'b0, hfb,  id_c, 32'h0,        32'h00800000};
    v[6]  = '{0, 1'b0, hfb,  id_c, 32'h0,        32'h00400000};
    v[7]  = '{0, 1'b1, hfb,  id_c, 32'h0,        32'h0};
    v[8]  = '{0, 1'b1, fir,  id_c, ONE,          ONE};
    v[9]  = '{0, 1'b0, fir,  id_c, 32'h0,        32'h00800000};
    v[10] = '{0, 1'b0, fir,  id_c, 32'h0,        32'h00400000};
    v[11] = '{0, 1'b0, fir,  id_c, 32'h0,        32'h0};
    v[12] = '{0, 1'b1, fb2c, id_c, ONE,          ONE};
    v[13] = '{0, 1'b0, fb2c, id_c, 32'h0,        32'h0};
    v[14] = '{0, 1'b0, fb2c, id_c, 32'h0,        32'h00400000};
    v[15] = '{0, 1'b0, big,  id_c, 32'h02000000, 32'h7FFFFFFF};
    v[16] = '{0, 1'b0, big,  id_c, 32'hFE000000, 32'h80000000};
    v[17] = '{1, 1'b0, big,  id_c, 32'h02000000, 32'hFE000000};
    v[18] = '{1, 1'b0, id_c, id_c, 32'h00123456, 32'h00123456};
    v[19] = '{1, 1'b1, hfb,  hfb,  ONE,          ONE};
    v[20] = '{1, 1'b0, hfb,  hfb,  32'h0,        ONE};

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_busy%0d", i), 64'(busy_o[i]), 64'd0);
      chk($sformatf("rst_fin%0d", i), 64'(fin_o[i]), 64'd0);
      chk($sformatf("rst_y%0d", i), 64'(y_o[i]), 64'd0);
      chk($sformatf("rst_ma%0d", i), 64'(ma[i]), 64'd0);
    end
    rst_n = 1;

    for (int i = 0; i < 21; i++) begin
      coef = {v[i].c1, v[i].c0};
      run(v[i].d, v[i].fl, v[i].x, v[i].e, $sformatf("vec%0d", i));
    end

    // start while busy must be ignored: one finish, original sample
    coef = {id_c, id_c};
    x = 32'h00ABCDEF; st[1] = 1;
    @(posedge clk); #1;
    st[1] = 0;
    nfin = 0; fcyc = 0; fy = 0;
    for (int c = 1; c < 30; c++) begin
      if (c == 4) begin x = 32'h11111111; st[1] = 1; end
      if (c == 5) st[1] = 0;
      if (fin_o[1]) begin nfin++; fcyc = c; fy = y_o[1]; end
      @(posedge clk); #1;
    end
    chk("busy_start_nfin", 64'(nfin), 64'd1);
    chk("busy_start_cyc", 64'(fcyc), 64'd15);
    chk("busy_start_y", 64'(fy), 64'h00ABCDEF);

    // reset during second section aborts and clears delay state
    coef = {id_c, hfb};
    run(1, 1'b1, ONE, ONE, "prime");
    x = 32'h0; st[1] = 1;
    @(posedge clk); #1;
    st[1] = 0;
    nfin = 0;
    for (int c = 1; c < 10; c++) begin
      if (fin_o[1]) nfin++;
      @(posedge clk); #1;
    end
    rst_n = 0;
    @(posedge clk); #1;
    chk("abort_nfin", 64'(nfin), 64'd0);
    chk("abort_busy", 64'(busy_o[1]), 64'd0);
    chk("abort_fin", 64'(fin_o[1]), 64'd0);
    chk("abort_ma", 64'(ma[1]), 64'd0);
    chk("abort_mb", 64'(mb[1]), 64'd0);
    chk("abort_y", 64'(y_o[1]), 64'd0);
    rst_n = 1;
    @(posedge clk); #1;
    run(1, 1'b0, ONE, ONE, "after_rst");
    run(1, 1'b0, 32'h0, 32'h00800000, "after_rst2");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
